fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one 8-bit FIFO write port among N valid/ready requesters. It grants one requester at a time and holds the grant for a whole packet, ending on `last` or after MAX_BURST beats, so that packets do not interleave in the FIFO. It sits directly in front of the FIFO write domain and drives `w_en`/`datain` from the FIFO `full` flag.

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 99 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;
   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

   localparam int DATA_W = 8;

   // Wraps idx back into 0..n-1; the caller guarantees idx < 2*n.
   function automatic int rr_wrap(input int idx, input int n);
      return (idx >= n) ? idx - n : idx;
   endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first valid requester after last_grant.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int N = 4,
   localparam int GW = $clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [GW-1:0] last_grant,
   output logic          found,
   output logic [GW-1:0] idx
);

   logic [GW-1:0] cand;

   // Scan from farthest to nearest so the nearest valid wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = N; k >= 1; k--) begin
         cand = GW'(rr_wrap(int'(last_grant) + k, N));
         if (valid[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter in front of a FIFO write port.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N = 4,
   parameter int MAX_BURST = 8,
   localparam int GW = $clog2(N),
   localparam int CW = $clog2(MAX_BURST + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        req_valid,
   input  logic [N-1:0]        req_last,
   input  logic [N*DATA_W-1:0] req_data,
   output logic [N-1:0]        req_ready,
   output logic                w_en,
   output logic [DATA_W-1:0]   datain,
   input  logic                full,
   output logic [GW-1:0]       grant_id,
   output logic                busy
);

   arb_state_t state, state_nxt;

   logic [GW-1:0]     last_grant, last_nxt;
   logic [GW-1:0]     gid_nxt, pick_idx;
   logic [CW-1:0]     beat_cnt, cnt_nxt;
   logic              pick_found;
   logic              rel;
   logic [DATA_W-1:0] data_arr [N];

   for (genvar i = 0; i < N; i++) begin : g_data
      assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
   end

   rr_pick #(.N(N)) u_pick (
      .valid      (req_valid),
      .last_grant (last_grant),
      .found      (pick_found),
      .idx        (pick_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= GW'(N - 1);
         beat_cnt   <= '0;
         grant_id   <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_nxt;
         beat_cnt   <= cnt_nxt;
         grant_id   <= gid_nxt;
      end
   end

   assign busy = (state == GRANT);

   // Datapath is purely combinational so a beat costs no extra cycle.
   always_comb begin
      req_ready = '0;
      w_en      = 1'b0;
      datain    = data_arr[0];
      if (busy) begin
         req_ready[grant_id] = ~full;
         w_en                = req_valid[grant_id] & ~full;
         datain              = data_arr[grant_id];
      end
   end

   assign rel = w_en &
      (req_last[grant_id] | (beat_cnt == CW'(MAX_BURST - 1)));

   always_comb begin
      state_nxt = state;
      gid_nxt   = grant_id;
      last_nxt  = last_grant;
      cnt_nxt   = beat_cnt;
      unique case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt = GRANT;
               gid_nxt   = pick_idx;
               cnt_nxt   = '0;
            end
         end
         GRANT: begin
            if (w_en) begin
               cnt_nxt = beat_cnt + 1'b1;
               if (rel) begin
                  state_nxt = IDLE;
                  last_nxt  = grant_id;
               end
            end
         end
      endcase
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table plus scoreboarded packet sequences.
module tb_fifo_wr_arbiter;
   import fifo_arb_pkg::*;

   localparam int N  = 4;
   localparam int MB = 8;

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
   } sb_t;

   typedef struct {
      logic [3:0] valid;
      logic [3:0] last;
      logic       full;
      logic       busy;
      logic [1:0] gid;
      logic       w_en;
      logic [3:0] ready;
      logic [7:0] din;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_last;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        w_en;
   logic [7:0]  datain;
   logic        full;
   logic [1:0]  grant_id;
   logic        busy;

   sb_t  sbq [$];
   vec_t tbl [22];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(.N(N), .MAX_BURST(MB)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_data  (req_data),
      .req_ready (req_ready),
      .w_en      (w_en),
      .datain    (datain),
      .full      (full),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] id, input logic [7:0] d);
      sb_t e;
      e.id   = id;
      e.data = d;
      sbq.push_back(e);
   endtask

   // Outputs are checked mid-cycle; any write seen must match the queue head.
   task automatic sample();
      sb_t e;
      @(negedge clk);
      if (w_en === 1'b1) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_unexpected: got write %0h from %0d expected none",
                     datain, grant_id);
         end else begin
            e = sbq.pop_front();
            chk("sb_data", datain, e.data);
            chk("sb_id", grant_id, e.id);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l,
                               input logic f, input logic b,
                               input logic [1:0] g, input logic w,
                               input logic [3:0] r, input logic [7:0] d);
      vec_t x;
      x.valid = v; x.last = l; x.full = f; x.busy = b;
      x.gid = g; x.w_en = w; x.ready = r; x.din = d;
      return x;
   endfunction

   initial begin
      tbl[0]  = mk(4'b0101, 4'b0101, 0, 0, 0, 0, 4'b0000, 8'h40);
      tbl[1]  = mk(4'b0101, 4'b0101, 0, 1, 0, 1, 4'b0001, 8'h40);
      tbl[2]  = mk(4'b0101, 4'b0101, 0, 0, 0, 0, 4'b0000, 8'h40);
      tbl[3]  = mk(4'b0101, 4'b0101, 0, 1, 2, 1, 4'b0100, 8'h42);
      tbl[4]  = mk(4'b0000, 4'b0000, 0, 0, 2, 0, 4'b0000, 8'h40);
      tbl[5]  = mk(4'b1111, 4'b1111, 0, 0, 2, 0, 4'b0000, 8'h40);
      tbl[6]  = mk(4'b1111, 4'b1111, 0, 1, 3, 1, 4'b1000, 8'h43);
      tbl[7]  = mk(4'b1111, 4'b1111, 0, 0, 3, 0, 4'b0000, 8'h40);
      tbl[8]  = mk(4'b1111, 4'b1111, 0, 1, 0, 1, 4'b0001, 8'h40);
      tbl[9]  = mk(4'b1111, 4'b1111, 0, 0, 0, 0, 4'b0000, 8'h40);
      tbl[10] = mk(4'b1111, 4'b1111, 0, 1, 1, 1, 4'b0010, 8'h41);
      tbl[11] = mk(4'b1111, 4'b1111, 0, 0, 1, 0, 4'b0000, 8'h40);
      tbl[12] = mk(4'b1111, 4'b1111, 0, 1, 2, 1, 4'b0100, 8'h42);
      tbl[13] = mk(4'b1111, 4'b1111, 0, 0, 2, 0, 4'b0000, 8'h40);
      tbl[14] = mk(4'b1111, 4'b1111, 0, 1, 3, 1, 4'b1000, 8'h43);
      tbl[15] = mk(4'b1111, 4'b1111, 0, 0, 3, 0, 4'b0000, 8'h40);
      tbl[16] = mk(4'b1111, 4'b1111, 0, 1, 0, 1, 4'b0001, 8'h40);
      tbl[17] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 8'h40);
      tbl[18] = mk(4'b0001, 4'b0001, 1, 0, 0, 0, 4'b0000, 8'h40);
      tbl[19] = mk(4'b0001, 4'b0001, 1, 1, 0, 0, 4'b0000, 8'h40);
      tbl[20] = mk(4'b0001, 4'b0001, 0, 1, 0, 1, 4'b0001, 8'h40);
      tbl[21] = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 4'b0000, 8'h40);

      rst       = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = 32'h43424140;
      full      = 1'b0;

      sample();
      chk("rst_busy", busy, 1'b0);
      chk("rst_wen", w_en, 1'b0);
      chk("rst_rdy", req_ready, 4'b0000);
      chk("rst_gid", grant_id, 2'd0);
      tick();
      rst = 1'b0;

      foreach (tbl[i]) begin
         req_valid = tbl[i].valid;
         req_last  = tbl[i].last;
         full      = tbl[i].full;
         if (tbl[i].w_en) push(tbl[i].gid, tbl[i].din);
         sample();
         chk($sformatf("t%0d_busy", i), busy, tbl[i].busy);
         chk($sformatf("t%0d_gid", i), grant_id, tbl[i].gid);
         chk($sformatf("t%0d_wen", i), w_en, tbl[i].w_en);
         chk($sformatf("t%0d_rdy", i), req_ready, tbl[i].ready);
         chk($sformatf("t%0d_din", i), datain, tbl[i].din);
         tick();
      end

      // Three-beat packet from 1 while 3 waits
      req_valid       = 4'b1010;
      req_last        = 4'b1000;
      req_data[15:8]  = 8'hA1;
      req_data[31:24] = 8'hD3;
      sample();
      chk("a_idle", busy, 1'b0);
      tick();
      push(1, 8'hA1);
      sample();
      chk("a_gid", grant_id, 2'd1);
      chk("a_rdy", req_ready, 4'b0010);
      tick();
      req_data[15:8] = 8'hA2;
      push(1, 8'hA2);
      sample();
      tick();
      req_data[15:8] = 8'hA3;
      req_last       = 4'b1010;
      push(1, 8'hA3);
      sample();
      tick();
      req_valid = 4'b1000;
      sample();
      chk("a_bubble", busy, 1'b0);
      tick();
      push(3, 8'hD3);
      sample();
      chk("a_next", grant_id, 2'd3);
      tick();
      req_valid = '0;
      req_last  = '0;
      sample();
      tick();

      // Requester 0 never sends last: MAX_BURST cut-off
      req_valid      = 4'b1111;
      req_last       = 4'b1110;
      req_data[15:8] = 8'h5A;
      for (int k = 0; k <= MB; k++) begin
         req_data[7:0] = 8'(8'h80 + k);
         if (k > 0) push(0, 8'(8'h80 + k));
         sample();
         chk($sformatf("b%0d_busy", k), busy, (k > 0));
         if (k > 0) chk($sformatf("b%0d_gid", k), grant_id, 2'd0);
         tick();
      end
      sample();
      chk("b_release", busy, 1'b0);
      tick();
      push(1, 8'h5A);
      sample();
      chk("b_next", grant_id, 2'd1);
      tick();
      req_valid = '0;
      req_last  = '0;
      sample();
      tick();

      // FIFO full stall inside a 7-beat packet from 2
      begin
         int b;
         b = 0;
         req_valid       = 4'b0100;
         req_data[23:16] = 8'hC0;
         sample();
         chk("c_idle", busy, 1'b0);
         tick();
         for (int i = 1; i <= 10; i++) begin
            full            = (i >= 3 && i <= 5);
            req_data[23:16] = 8'(8'hC0 + b);
            req_last[2]     = (b == 6);
            if (!full) push(2, 8'(8'hC0 + b));
            sample();
            chk($sformatf("c%0d_busy", i), busy, 1'b1);
            chk($sformatf("c%0d_gid", i), grant_id, 2'd2);
            chk($sformatf("c%0d_wen", i), w_en, !full);
            chk($sformatf("c%0d_rdy", i), req_ready,
                full ? 4'b0000 : 4'b0100);
            tick();
            if (!full) b++;
         end
         full      = 1'b0;
         req_valid = '0;
         req_last  = '0;
         sample();
         chk("c_done", busy, 1'b0);
         tick();
      end

      // Asynchronous reset two beats into a packet from 1
      req_valid      = 4'b0010;
      req_data[15:8] = 8'hE0;
      sample();
      chk("d_idle", busy, 1'b0);
      tick();
      push(1, 8'hE0);
      sample();
      chk("d_gid", grant_id, 2'd1);
      tick();
      req_data[15:8] = 8'hE1;
      push(1, 8'hE1);
      sample();
      tick();
      req_data[15:8] = 8'hE2;
      #1 rst = 1'b1;
      #1;
      chk("d_async_busy", busy, 1'b0);
      chk("d_async_wen", w_en, 1'b0);
      chk("d_async_rdy", req_ready, 4'b0000);
      chk("d_async_gid", grant_id, 2'd0);
      sample();
      tick();
      sample();
      chk("d_rst_edge", busy, 1'b0);
      tick();
      rst           = 1'b0;
      req_valid     = 4'b1111;
      req_last      = 4'b1111;
      req_data[7:0] = 8'hF0;
      sample();
      chk("d_post_idle", busy, 1'b0);
      tick();
      push(0, 8'hF0);
      sample();
      chk("d_prio", grant_id, 2'd0);
      chk("d_prio_busy", busy, 1'b1);
      tick();
      req_valid = '0;
      req_last  = '0;
      sample();
      tick();

      chk("sb_drain", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
